// File: rtl/ram_shadow_scanner.sv
// Double-buffered shadow of the data RAM for the VGA path: each accepted vblank
// copies DEPTH bytes into the back bank, then swaps it to the front.
module ram_shadow_scanner #(
  parameter int DEPTH = 65,
  parameter int AW    = 7,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          vblank_start,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic [DW-1:0] mem_rdata,
  input  logic [AW-1:0] vga_addr,
  output logic [DW-1:0] vga_data,
  output logic          busy,
  output logic          frame_done,
  output logic [7:0]    overrun_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    SWAP  = 2'd3
  } state_t;

  localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH-1);

  state_t        r_state;
  logic          r_front;
  logic [AW-1:0] r_addr;
  logic          r_mem_req;
  logic          r_busy;
  logic          r_frame_done;
  logic [7:0]    r_overrun;
  logic          r_rvalid;
  logic [AW-1:0] r_wptr;
  logic [DW-1:0] r_vga_data;

  // Both banks live in one array; the MSB of the index selects the bank.
  logic [DW-1:0] r_bank [0:(2**(AW+1))-1];

  logic w_vga_in_range;
  assign w_vga_in_range = {1'b0, vga_addr} < DEPTH_EXT;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_front      <= 1'b0;
      r_addr       <= '0;
      r_mem_req    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 8'd0;
      r_rvalid     <= 1'b0;
      r_wptr       <= '0;
    end else begin
      r_rvalid     <= r_mem_req && mem_gnt;
      r_wptr       <= r_addr;
      r_frame_done <= 1'b0;
      if (vblank_start && (r_state != IDLE) && (r_overrun != 8'hFF))
        r_overrun <= r_overrun + 8'd1;
      case (r_state)
        IDLE: begin
          if (vblank_start && enable) begin
            r_state   <= FETCH;
            r_addr    <= '0;
            r_mem_req <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        FETCH: begin
          // Address stays on the last byte so mem_addr never leaves 0..DEPTH-1.
          if (mem_gnt) begin
            if (r_addr == LAST_ADDR) begin
              r_state   <= DRAIN;
              r_mem_req <= 1'b0;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        DRAIN: begin
          r_state      <= SWAP;
          r_frame_done <= 1'b1;
        end
        SWAP: begin
          r_state <= IDLE;
          r_front <= ~r_front;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_rvalid)
      r_bank[{~r_front, r_wptr}] <= mem_rdata;
  end

  // Bank select is sampled before the swap edge, so a SWAP-cycle read sees the old bank.
  always_ff @(posedge clk) begin
    if (!reset)
      r_vga_data <= '0;
    else
      r_vga_data <= w_vga_in_range ? r_bank[{r_front, vga_addr}] : '0;
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_addr;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign overrun_cnt = r_overrun;
  assign vga_data    = r_vga_data;

endmodule
